hs_responder: RTL and testbench

Receive end of a four-phase req/ack handshake that crosses data into the `clk` domain. The initiator lives in another clock domain, holds `data_in` stable, then raises `req_in`. This block synchronizes `req_in`, captures the bus, and presents it downstream with a valid/ready handshake. It returns `ack_out` only after the word has been consumed. It is the destination-side counterpart to the initiator-side register and strobe logic in the synchronizer test designs.

---
 rtl/hs_responder_if.sv | 30 +++
 rtl/hs_responder.sv | 153 +++++++++++++++
 tb/tb_hs_responder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_responder_if.sv
// Handshake bundle for hs_responder: foreign-domain req/ack/data on one side,
// downstream valid/ready/data on the other.
interface hs_responder_if #(
  parameter int N = 8
);
  logic         req_in;
  logic [N-1:0] data_in;
  logic         ack_out;
  logic [N-1:0] data_out;
  logic         valid_out;
  logic         rdy_in;

  modport slave (
    input  req_in,
    input  data_in,
    input  rdy_in,
    output ack_out,
    output data_out,
    output valid_out
  );

  modport master (
    output req_in,
    output data_in,
    output rdy_in,
    input  ack_out,
    input  data_out,
    input  valid_out
  );
endinterface

// File: rtl/hs_responder.sv
// Receive side of a four-phase req/ack clock-domain crossing; presents the word downstream
// with valid/ready. Optional protocol-violation counter built when HS_ERR_CNT_EN is defined.
module hs_responder #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  hs_responder_if.slave        hs,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_s;
  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [N-1:0]           data_r;
  logic                   valid_r;
  logic                   ack_r;
  logic                   busy_r;
  logic                   load_s;
  logic                   valid_nxt_s;
  logic                   ack_nxt_s;
  logic                   busy_nxt_s;

  // req_in synchronizer chain; data_in is only sampled once req_s is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], hs.req_in};
    end
  end

  assign req_s = sync_r[SYNC_STAGES-1];

  // state register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      data_r  <= {N{1'b0}};
      valid_r <= 1'b0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= valid_nxt_s;
      ack_r   <= ack_nxt_s;
      busy_r  <= busy_nxt_s;
      if (load_s) begin
        data_r <= hs.data_in;
      end else begin
        data_r <= data_r;
      end
    end
  end

  // next-state: ena gates only new captures, never a transfer in flight
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ena && req_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hs.rdy_in) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // outputs are decoded from the next state so ack/valid/busy leave straight from flops
  always_comb begin
    valid_nxt_s = 1'b0;
    ack_nxt_s   = 1'b0;
    busy_nxt_s  = 1'b1;
    load_s      = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_HOLD: begin
        valid_nxt_s = 1'b1;
        load_s      = (state_r == ST_IDLE);
      end
      ST_ACK: begin
        ack_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  assign hs.data_out  = data_r;
  assign hs.valid_out = valid_r;
  assign hs.ack_out   = ack_r;
  assign busy         = busy_r;

`ifdef HS_ERR_CNT_EN
  logic       req_d_r;
  logic [7:0] err_cnt_r;
  logic       viol_s;

  // request withdrawn while the word is still waiting for the consumer
  assign viol_s = (state_r == ST_HOLD) && req_d_r && !req_s;

  // saturating violation counter; cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d_r   <= 1'b0;
      err_cnt_r <= 8'd0;
    end else begin
      req_d_r <= req_s;
      if (viol_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_hs_responder.sv
// Self-checking bench for hs_responder: cycle model of the transfer rules, per-cycle compare,
// word scoreboard at the valid/ready handshake, directed and randomized transfers.
module tb_hs_responder;
  localparam int N  = 8;
  localparam int SS = 2;
`ifdef HS_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       busy;
  logic [7:0] err_cnt;

  hs_responder_if #(.N(N)) hs_if ();

  hs_responder #(.N(N), .SYNC_STAGES(SS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .hs     (hs_if),
    .busy   (busy),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_fail = 0;
  bit           rnd_mode = 1'b0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the FSM sees req_in delayed by SS edges; a word is pending, then acknowledged
  logic [SS-1:0] m_hist;
  logic          m_seen;
  logic          m_prev;
  logic          m_valid;
  logic          m_ack;
  logic [N-1:0]  m_data;
  logic [7:0]    m_err;

  assign m_seen = m_hist[SS-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist  <= {SS{1'b0}};
      m_prev  <= 1'b0;
      m_valid <= 1'b0;
      m_ack   <= 1'b0;
      m_data  <= {N{1'b0}};
      m_err   <= 8'd0;
    end else begin
      m_hist <= {m_hist[SS-2:0], hs_if.req_in};
      m_prev <= m_seen;
      if (m_valid) begin
        if (m_prev && !m_seen && m_err != 8'd255) m_err <= m_err + 8'd1;
        if (hs_if.rdy_in) begin
          m_valid <= 1'b0;
          m_ack   <= 1'b1;
        end
      end else if (m_ack) begin
        if (!m_seen) m_ack <= 1'b0;
      end else if (ena && m_seen) begin
        m_valid <= 1'b1;
        m_data  <= hs_if.data_in;
      end
    end
  end

  // per-cycle compare on the falling edge, plus the handshake scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid_out", hs_if.valid_out, m_valid);
      chk("ack_out", hs_if.ack_out, m_ack);
      chk("busy", busy, m_valid | m_ack);
      chk("err_cnt", err_cnt, ERR_EN ? m_err : 8'd0);
      if (m_valid) chk("data_out", hs_if.data_out, m_data);
      if (hs_if.valid_out && hs_if.rdy_in) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL handshake_extra: got word %0h, required none", hs_if.data_out);
        end else begin
          chk("handshake_word", hs_if.data_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    if (rnd_mode) begin
      hs_if.rdy_in = ($urandom_range(0, 2) != 0);
      ena          = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_ack(input logic val, input int budget);
    int k = 0;
    while (hs_if.ack_out !== val && k < budget) begin
      cyc();
      k++;
    end
    chk(val ? "ack_rise_bound" : "ack_fall_bound", hs_if.ack_out, val);
  endtask

  task automatic xfer(input logic [N-1:0] d);
    hs_if.data_in = d;
    hs_if.req_in  = 1'b1;
    exp_q.push_back(d);
    wait_ack(1'b1, 400);
    hs_if.req_in = 1'b0;
    wait_ack(1'b0, 40);
    repeat ($urandom_range(0, 2)) cyc();
  endtask

  task automatic violate(input logic [N-1:0] d);
    int k = 0;
    hs_if.rdy_in  = 1'b0;
    hs_if.data_in = d;
    hs_if.req_in  = 1'b1;
    exp_q.push_back(d);
    while (hs_if.valid_out !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    chk("viol_capture", hs_if.valid_out, 1'b1);
    hs_if.req_in = 1'b0;
    repeat (SS + 1) cyc();
    chk("viol_still_held", hs_if.valid_out, 1'b1);
    hs_if.rdy_in = 1'b1;
    cyc();
    chk("viol_ack_pulse", hs_if.ack_out, 1'b1);
    cyc();
    chk("viol_ack_end", hs_if.ack_out, 1'b0);
    chk("viol_idle", busy, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    ena           = 1'b0;
    hs_if.req_in  = 1'b0;
    hs_if.data_in = {N{1'b0}};
    hs_if.rdy_in  = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", hs_if.valid_out, 1'b0);
    chk("rst_ack", hs_if.ack_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", hs_if.data_out, 8'h00);
    chk("rst_err", err_cnt, 8'h00);
    rst_n = 1'b1;
    ena   = 1'b1;
    cyc();

    // basic transfer, rdy held high
    hs_if.data_in = 8'hA5;
    hs_if.req_in  = 1'b1;
    hs_if.rdy_in  = 1'b1;
    exp_q.push_back(8'hA5);
    cyc();
    cyc();
    chk("a5_valid_edge1", hs_if.valid_out, 1'b0);
    cyc();
    chk("a5_valid_edge2", hs_if.valid_out, 1'b1);
    chk("a5_data", hs_if.data_out, 8'hA5);
    chk("a5_ack_edge2", hs_if.ack_out, 1'b0);
    cyc();
    chk("a5_ack_edge3", hs_if.ack_out, 1'b1);
    chk("a5_valid_edge3", hs_if.valid_out, 1'b0);
    hs_if.req_in = 1'b0;
    cyc();
    cyc();
    chk("a5_ack_rel1", hs_if.ack_out, 1'b1);
    cyc();
    chk("a5_ack_rel2", hs_if.ack_out, 1'b0);
    chk("a5_busy_rel2", busy, 1'b0);
    cyc();

    // consumer stalls for 10 cycles
    hs_if.rdy_in  = 1'b0;
    hs_if.data_in = 8'h3C;
    hs_if.req_in  = 1'b1;
    exp_q.push_back(8'h3C);
    repeat (SS + 1) cyc();
    for (int i = 0; i < 10; i++) begin
      chk("3c_valid_held", hs_if.valid_out, 1'b1);
      chk("3c_data_held", hs_if.data_out, 8'h3C);
      chk("3c_no_ack", hs_if.ack_out, 1'b0);
      cyc();
    end
    hs_if.rdy_in = 1'b1;
    cyc();
    chk("3c_ack", hs_if.ack_out, 1'b1);
    hs_if.req_in = 1'b0;
    wait_ack(1'b0, 10);
    chk("3c_idle", busy, 1'b0);
    cyc();

    // ena low blocks capture; raising it with req still high captures once
    ena           = 1'b0;
    hs_if.data_in = 8'hFF;
    hs_if.req_in  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("ena0_busy", busy, 1'b0);
    end
    ena = 1'b1;
    exp_q.push_back(8'hFF);
    cyc();
    chk("ena1_valid", hs_if.valid_out, 1'b1);
    chk("ena1_data", hs_if.data_out, 8'hFF);
    wait_ack(1'b1, 10);
    hs_if.req_in = 1'b0;
    wait_ack(1'b0, 10);
    repeat (5) cyc();
    chk("ena1_once_idle", busy, 1'b0);

    // request withdrawn during HOLD
    violate(8'h11);
    chk("viol_err_one", err_cnt, ERR_EN ? 8'd1 : 8'd0);
    for (int i = 1; i < 300; i++) violate(8'($urandom));
    chk("viol_err_sat", err_cnt, ERR_EN ? 8'd255 : 8'd0);

    // reset while acknowledging
    hs_if.data_in = 8'h5A;
    hs_if.req_in  = 1'b1;
    hs_if.rdy_in  = 1'b1;
    exp_q.push_back(8'h5A);
    wait_ack(1'b1, 10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", hs_if.ack_out, 1'b0);
    chk("arst_valid", hs_if.valid_out, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_data", hs_if.data_out, 8'h00);
    chk("arst_err", err_cnt, 8'h00);
    hs_if.req_in = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("arst_idle_busy", busy, 1'b0);
    chk("arst_idle_valid", hs_if.valid_out, 1'b0);

    // back-to-back incrementing pattern, then random words, random ready/enable
    rnd_mode = 1'b1;
    for (int i = 0; i < 100; i++) xfer(8'(i));
    for (int i = 0; i < 40; i++) xfer(8'($urandom));
    rnd_mode     = 1'b0;
    ena          = 1'b1;
    hs_if.rdy_in = 1'b1;
    repeat (4) cyc();
    chk("all_words_delivered", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
